// File: rtl/tartaruga_pkg.sv
// Shared types for the data-cache line refill/write-back memory responder.
package tartaruga_pkg;

    localparam int LINE_BITS = 128;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_t;

endpackage

// File: rtl/mem_line_responder_line_ram.sv
// Single-port line-wide synchronous RAM; a write takes priority and read data appears one cycle after re_i.
module line_ram #(
    parameter int LINE_BITS   = 128,
    parameter int DEPTH_LINES = 1024,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end else if (re_i) begin
            rdata_o <= mem_q[idx_i];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for dcache line refill/write-back: one request in flight, fixed LATENCY to response.
// Optional MEM_ADDR_CHECK_EN adds rsp_err_o and rejects lines beyond DEPTH_LINES instead of wrapping.
module mem_line_responder
    import tartaruga_pkg::*;
#(
    parameter int LINE_BITS   = tartaruga_pkg::LINE_BITS,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_addr_i,
    input  logic                 req_we_i,
    input  logic [LINE_BITS-1:0] req_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [LINE_BITS-1:0] rsp_data_o,
    output logic [31:0]          rsp_addr_o
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                 rsp_err_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_line_responder: LATENCY must be within 1..15");
    end

    mem_rsp_state_t       state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 accept, commit;
    logic [27:0]          line_q;
    logic                 we_q;
    logic [LINE_BITS-1:0] data_q;
    logic                 oor_d, oor_q;
    logic [31:0]          rsp_addr_q;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr_i[3:0];

`ifdef MEM_ADDR_CHECK_EN
    // Any set bit above the index field means the line lies beyond the array.
    assign oor_d = |req_addr_i[31:4+IDX_W];
`else
    assign oor_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rsp_addr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                rsp_addr_q <= {line_q, 4'b0000};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            line_q <= req_addr_i[31:4];
            we_q   <= req_we_i;
            data_q <= req_data_i;
            oor_q  <= oor_d;
        end
    end

    // Commit happens on the last WAIT cycle so a read lands exactly on RESP entry; reset drops it.
    line_ram #(
        .LINE_BITS   (LINE_BITS),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_line_ram (
        .clk_i   (clk_i),
        .we_i    (commit && we_q && !oor_q && !rst_i),
        .re_i    (commit && !we_q),
        .idx_i   (line_q[IDX_W-1:0]),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_data_o  = (state_q == RESP && !oor_q) ? (we_q ? data_q : ram_rdata) : '0;
`ifdef MEM_ADDR_CHECK_EN
    assign rsp_err_o   = (state_q == RESP) && oor_q;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized self-checking bench for mem_line_responder (LATENCY=4 and LATENCY=1 instances).
module tb_mem_line_responder;
    import tartaruga_pkg::*;

    localparam int LAT0  = 4;
    localparam int LAT1  = 1;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    line_t       req_data  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    line_t       rsp_data  [2];
    logic [31:0] rsp_addr  [2];
`ifdef MEM_ADDR_CHECK_EN
    logic        rsp_err   [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cnt [2] = '{0, 0};
    int acc_last[2] = '{0, 0};
    int acc_prev[2] = '{0, 0};
    int hs_cnt  [2] = '{0, 0};
    int hs_last [2] = '{0, 0};

    // Reference memory: what each line should hold, and whether it has ever been written.
    line_t mem_m [2][DEPTH];
    bit    known [2][DEPTH];

    always #5 clk = ~clk;

    mem_line_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_we_i(req_we[0]), .req_data_i(req_data[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
        .rsp_addr_o(rsp_addr[0])
`ifdef MEM_ADDR_CHECK_EN
        , .rsp_err_o(rsp_err[0])
`endif
    );

    mem_line_responder #(.DEPTH_LINES(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_we_i(req_we[1]), .req_data_i(req_data[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
        .rsp_addr_o(rsp_addr[1])
`ifdef MEM_ADDR_CHECK_EN
        , .rsp_err_o(rsp_err[1])
`endif
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (req_valid[d] && req_ready[d]) begin
                acc_cnt[d]  <= acc_cnt[d] + 1;
                acc_prev[d] <= acc_last[d];
                acc_last[d] <= cyc;
            end
            if (rsp_valid[d] && rsp_ready[d]) begin
                hs_cnt[d]  <= hs_cnt[d] + 1;
                hs_last[d] <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] addr);
`ifdef MEM_ADDR_CHECK_EN
        return addr[31:4] >= 28'(DEPTH);
`else
        return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One full request/response with expectations from the reference memory; hold = cycles of rsp backpressure.
    task automatic do_txn(input int d, input logic [31:0] addr, input logic we, input line_t data, input int hold);
        int    lat, waitc, idx, a_before, lat_exp;
        bit    oor, chk_d;
        line_t exp_d, got_d;
        logic [31:0] got_a;
        lat_exp = (d == 0) ? LAT0 : LAT1;
        idx     = int'(addr[13:4]);
        oor     = out_of_range(addr);
        if (we) begin
            exp_d = oor ? '0 : data;
            chk_d = 1'b1;
        end else begin
            exp_d = oor ? '0 : mem_m[d][idx];
            chk_d = oor || known[d][idx];
        end
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_we[d]    = we;
        req_data[d]  = data;
        rsp_ready[d] = (hold == 0);
        waitc = 0;
        while (!req_ready[d] && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_in_time", waitc < 50, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = ~addr;
        req_data[d]  = ~data;
        a_before     = acc_cnt[d];
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid[d] && lat < 40);
        got_d = rsp_data[d];
        got_a = rsp_addr[d];
        check("latency", lat, lat_exp);
        check("rsp_addr", got_a, {addr[31:4], 4'b0000});
        if (chk_d) check("rsp_data", got_d, exp_d);
        check("ready_low_in_resp", req_ready[d], 1'b0);
`ifdef MEM_ADDR_CHECK_EN
        check("rsp_err", rsp_err[d], oor);
`endif
        if (hold > 0) begin
            @(negedge clk);
            req_valid[d] = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check("bp_valid", rsp_valid[d], 1'b1);
                check("bp_data", rsp_data[d], got_d);
                check("bp_addr", rsp_addr[d], got_a);
            end
            check("bp_no_accept", acc_cnt[d], a_before);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_drop", rsp_valid[d], 1'b0);
        check("ready_back", req_ready[d], 1'b1);
        if (we && !oor) begin
            mem_m[d][idx] = data;
            known[d][idx] = 1'b1;
        end
    endtask

    function automatic line_t rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        line_t       l1, p, q;
        logic [31:0] a;
        int          a0, h0, waitc;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; req_we[d] = 1'b0;
            req_data[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", req_ready[d], 1'b1);
            check("rst_valid", rsp_valid[d], 1'b0);
            check("rst_data", rsp_data[d], '0);
            check("rst_addr", rsp_addr[d], 32'd0);
`ifdef MEM_ADDR_CHECK_EN
            check("rst_err", rsp_err[d], 1'b0);
`endif
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Write then read-back of the same line through a non-aligned address.
        l1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        do_txn(0, 32'h0000_0040, 1'b1, l1, 0);
        do_txn(0, 32'h0000_004C, 1'b0, '0, 0);

        // req_valid held high across two reads: accepts spaced by LATENCY+2.
        @(negedge clk);
        a0 = acc_cnt[0];
        h0 = hs_cnt[0];
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0000_0040; rsp_ready[0] = 1'b1;
        waitc = 0;
        while (acc_cnt[0] - a0 < 2 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        req_valid[0] = 1'b0;
        check("two_accepts", acc_cnt[0] - a0, 2);
        check("accept_after_hs", acc_last[0], hs_last[0] + 1);
        check("accept_spacing", acc_last[0] - acc_prev[0], LAT0 + 2);
        waitc = 0;
        while (hs_cnt[0] - h0 < 2 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("two_responses", hs_cnt[0] - h0, 2);
        check("no_third_accept", acc_cnt[0] - a0, 2);

        // Backpressure for 10 cycles.
        do_txn(0, 32'h0000_0040, 1'b0, '0, 10);

        // Reset while a write sits in WAIT with two cycles left: write must be dropped.
        p = rnd_line();
        q = ~p;
        do_txn(0, 32'h0000_0080, 1'b1, p, 0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_0080; req_data[0] = q;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", rsp_valid[0], 1'b0);
        check("midrst_ready", req_ready[0], 1'b1);
        check("midrst_data", rsp_data[0], '0);
        check("midrst_addr", rsp_addr[0], 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        do_txn(0, 32'h0000_0080, 1'b0, '0, 0);

        // Address wrap (or rejection when range checking is built in).
        do_txn(0, 32'h0000_0010, 1'b1, rnd_line(), 0);
        do_txn(0, 32'h0000_4010, 1'b1, rnd_line(), 0);
        do_txn(0, 32'h0000_0010, 1'b0, '0, 0);

        // LATENCY=1: write-back then refill to a different, known line.
        do_txn(1, 32'h0000_0200, 1'b1, rnd_line(), 0);
        do_txn(1, 32'h0000_0300, 1'b1, rnd_line(), 0);
        do_txn(1, 32'h0000_0200, 1'b0, '0, 0);
        do_txn(1, 32'h0000_0300, 1'b0, '0, 0);

        // Randomized traffic on a handful of lines so reads often hit earlier writes.
        for (int i = 0; i < 90; i++) begin
            int d;
            d = (i < 60) ? 0 : 1;
            a = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_C000) : 32'd0;
            a = a | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            do_txn(d, a, 1'($urandom_range(0, 1)), rnd_line(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
